// File: rtl/data_ram_stream_writer_if.sv
// Stream sink bundle feeding the data RAM writer: Avalon-ST style beat
// handshake with frame delimiters. The source drives the beat and the
// writer returns sink_ready.
interface data_ram_stream_writer_if;
  logic        sink_valid;
  logic        sink_ready;
  logic [31:0] sink_data;
  logic        sink_startofpacket;
  logic        sink_endofpacket;

  modport master (
    output sink_valid,
    output sink_data,
    output sink_startofpacket,
    output sink_endofpacket,
    input  sink_ready
  );

  modport slave (
    input  sink_valid,
    input  sink_data,
    input  sink_startofpacket,
    input  sink_endofpacket,
    output sink_ready
  );
endinterface

// File: rtl/data_ram_stream_writer.sv
// Writes framed stream beats into one half of a ping-pong data RAM and
// publishes the bank of the newest complete frame to the reader side.
// Malformed, oversized or aborted frames are never published, so the
// reader always sees a stable, fully written bank.
module data_ram_stream_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int BANK_WORDS = 512
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  data_ram_stream_writer_if.slave    sink,
  output logic [ADDR_WIDTH-1:0]      address2,
  output logic [31:0]                writedata2,
  output logic                       write2,
  output logic                       chipselect2,
  output logic [3:0]                 byteenable2,
  output logic                       clken2,
  output logic                       ready_bank,
  output logic [ADDR_WIDTH-1:0]      ready_words,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  output logic [7:0]                 err_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Offset value meaning "bank is full": one more beat overflows the frame.
  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(BANK_WORDS);

  logic [1:0]            state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [7:0]            err_q, err_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  rbank_q, rbank_d;
  logic [ADDR_WIDTH-1:0] rwords_q, rwords_d;
  logic                  done_q, done_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  start;
  logic                  wr_beat;
  logic                  err_hit;
  logic [ADDR_WIDTH-1:0] wr_off;

  // Error counter holds at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sink.sink_ready = enable;

  // Frame FSM: classify the accepted beat, then build the RAM write and publish.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    offset_d  = offset_q;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    rbank_d   = rbank_q;
    rwords_d  = rwords_q;
    done_d    = 1'b0;
    write_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    start     = 1'b0;
    wr_beat   = 1'b0;
    err_hit   = 1'b0;

    if (!enable) begin
      // Losing enable abandons any partial frame but keeps the write bank.
      state_d  = ST_IDLE;
      offset_d = '0;
    end else if (sink.sink_valid) begin
      case (state_q)
        ST_WRITE: begin
          if (sink.sink_startofpacket) begin
            err_hit = 1'b1;
            start   = 1'b1;
          end else if (offset_q == FULL) begin
            err_hit = 1'b1;
            state_d = ST_DROP;
          end else begin
            wr_beat = 1'b1;
          end
        end
        ST_DROP: begin
          if (sink.sink_endofpacket) state_d = ST_IDLE;
          else if (sink.sink_startofpacket) start = 1'b1;
        end
        default: begin
          if (sink.sink_startofpacket) start = 1'b1;
          else err_hit = 1'b1;
        end
      endcase
    end

    wr_off = start ? '0 : offset_q;

    if (start || wr_beat) begin
      write_d = 1'b1;
      addr_d  = {wr_bank_q, wr_off[ADDR_WIDTH-2:0]};
      wdata_d = sink.sink_data;
      if (sink.sink_endofpacket) begin
        // Publish lands on the same edge as the frame's final write.
        rbank_d   = wr_bank_q;
        rwords_d  = wr_off + ADDR_WIDTH'(1);
        wr_bank_d = ~wr_bank_q;
        fcnt_d    = fcnt_q + 16'd1;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
        offset_d  = '0;
      end else begin
        state_d  = ST_WRITE;
        offset_d = wr_off + ADDR_WIDTH'(1);
      end
    end

    if (err_hit) err_d = sat_inc8(err_q);
  end

  // State and output registers; reset clears everything the reader can see.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_bank_q <= 1'b0;
      offset_q  <= '0;
      err_q     <= '0;
      fcnt_q    <= '0;
      rbank_q   <= 1'b0;
      rwords_q  <= '0;
      done_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      offset_q  <= offset_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      rbank_q   <= rbank_d;
      rwords_q  <= rwords_d;
      done_q    <= done_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign address2    = addr_q;
  assign writedata2  = wdata_q;
  assign write2      = write_q;
  assign chipselect2 = write_q;
  assign byteenable2 = 4'hF;
  assign clken2      = 1'b1;
  assign ready_bank  = rbank_q;
  assign ready_words = rwords_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_data_ram_stream_writer.sv
// Bench for the ping-pong data RAM stream writer: directed frame scenarios
// plus randomized traffic against a frame-level reference model.
module tb_data_ram_stream_writer;
  localparam int AW = 10;
  localparam int BW = 512;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [AW-1:0] address2;
  logic [31:0]   writedata2;
  logic          write2;
  logic          chipselect2;
  logic [3:0]    byteenable2;
  logic          clken2;
  logic          ready_bank;
  logic [AW-1:0] ready_words;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic [7:0]    err_count;

  int errors = 0;
  int checks = 0;

  data_ram_stream_writer_if sif ();

  data_ram_stream_writer #(.ADDR_WIDTH(AW), .BANK_WORDS(BW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sink        (sif),
    .address2    (address2),
    .writedata2  (writedata2),
    .write2      (write2),
    .chipselect2 (chipselect2),
    .byteenable2 (byteenable2),
    .clken2      (clken2),
    .ready_bank  (ready_bank),
    .ready_words (ready_words),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is the queue of words collected since its SOP.
  logic [31:0]   frame_q[$];
  logic          collecting, discarding, m_bank;
  logic          m_write, m_done, m_rbank;
  logic [AW-1:0] m_addr, m_rwords;
  logic [31:0]   m_data;
  logic [15:0]   m_fc;
  logic [7:0]    m_ec;

  task automatic model_reset();
    frame_q.delete();
    collecting = 0; discarding = 0; m_bank = 0;
    m_write = 0; m_done = 0; m_rbank = 0; m_addr = '0; m_rwords = '0;
    m_data = '0; m_fc = '0; m_ec = '0;
  endtask

  task automatic model_err();
    if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
  endtask

  task automatic model_step();
    logic start, wr;
    logic sop, eop;
    if (!reset_n) begin model_reset(); return; end
    m_write = 0; m_done = 0; start = 0; wr = 0;
    sop = sif.sink_startofpacket; eop = sif.sink_endofpacket;
    if (!enable) begin
      collecting = 0; discarding = 0;
    end else if (sif.sink_valid) begin
      if (discarding) begin
        if (eop) discarding = 0;
        else if (sop) start = 1;
      end else if (sop) begin
        if (collecting) model_err();
        start = 1;
      end else if (!collecting) begin
        model_err();
      end else if (frame_q.size() == BW) begin
        model_err(); collecting = 0; discarding = 1;
      end else begin
        frame_q.push_back(sif.sink_data); wr = 1;
      end
      if (start) begin
        frame_q.delete(); frame_q.push_back(sif.sink_data);
        collecting = 1; discarding = 0; wr = 1;
      end
      if (wr) begin
        m_write = 1;
        m_addr  = AW'(int'(m_bank) * BW + frame_q.size() - 1);
        m_data  = sif.sink_data;
        if (eop) begin
          m_done = 1; m_rbank = m_bank; m_rwords = AW'(frame_q.size());
          m_bank = ~m_bank; m_fc = m_fc + 16'd1; collecting = 0;
        end
      end
    end
  endtask

  function automatic logic [79:0] dut_vec();
    return {write2, chipselect2, address2, writedata2, frame_done, ready_bank,
            ready_words, frame_count, err_count};
  endfunction

  function automatic logic [79:0] exp_vec();
    return {m_write, m_write, m_addr, m_data, m_done, m_rbank, m_rwords, m_fc, m_ec};
  endfunction

  task automatic cycle(input logic en, input logic v, input logic sop,
                       input logic eop, input logic [31:0] d);
    @(negedge clk);
    enable = en; sif.sink_valid = v; sif.sink_startofpacket = sop;
    sif.sink_endofpacket = eop; sif.sink_data = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 0; sif.sink_valid = 0; enable = 1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 0; enable = 1; sif.sink_valid = 1;
    sif.sink_startofpacket = 1; sif.sink_endofpacket = 1; sif.sink_data = $urandom;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 80'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec()); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 80'd0) begin errors++; $display("FAIL reset_hold got=%h exp=0", dut_vec()); end
    checks++;
    if ({byteenable2, clken2, sif.sink_ready} !== 6'b111111) begin
      errors++; $display("FAIL reset_ties got=%b exp=111111", {byteenable2, clken2, sif.sink_ready});
    end
    @(negedge clk);
    sif.sink_valid = 0;
    reset_n = 1;
  endtask

  task automatic test_basic();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    cycle(1, 1, 1, 0, a);
    checks++;
    if ({write2, address2, writedata2, frame_done} !== {1'b1, 10'd0, a, 1'b0}) begin
      errors++; $display("FAIL basic_A got=%b/%0d/%h exp=1/0/%h", write2, address2, writedata2, a);
    end
    cycle(1, 1, 0, 0, b);
    checks++;
    if ({write2, address2, writedata2, frame_done} !== {1'b1, 10'd1, b, 1'b0}) begin
      errors++; $display("FAIL basic_B got=%b/%0d/%h exp=1/1/%h", write2, address2, writedata2, b);
    end
    cycle(1, 1, 0, 1, c);
    checks++;
    if ({write2, address2, writedata2, frame_done, ready_bank, ready_words, frame_count} !==
        {1'b1, 10'd2, c, 1'b1, 1'b0, 10'd3, 16'd1}) begin
      errors++;
      $display("FAIL basic_C got=w%b a%0d d%h done%b rb%b rw%0d fc%0d exp=w1 a2 d%h done1 rb0 rw3 fc1",
               write2, address2, writedata2, frame_done, ready_bank, ready_words, frame_count, c);
    end
    cycle(1, 0, 0, 0, 32'd0);
    checks++;
    if ({write2, frame_done} !== 2'b00) begin
      errors++; $display("FAIL basic_after got=w%b done%b exp=w0 done0", write2, frame_done);
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    d = $urandom;
    cycle(1, 1, 1, 1, d);
    checks++;
    if ({write2, address2, writedata2, frame_done, ready_bank, ready_words, frame_count} !==
        {1'b1, 10'd512, d, 1'b1, 1'b1, 10'd1, 16'd2}) begin
      errors++;
      $display("FAIL single got=w%b a%0d done%b rb%b rw%0d fc%0d exp=w1 a512 done1 rb1 rw1 fc2",
               write2, address2, frame_done, ready_bank, ready_words, frame_count);
    end
    cycle(1, 0, 0, 0, 32'd0);
  endtask

  task automatic test_overflow();
    int nw, nd;
    logic [7:0] e0;
    logic [15:0] f0;
    nw = 0; nd = 0; e0 = err_count; f0 = frame_count;
    for (int i = 0; i < 514; i++) begin
      cycle(1, 1, i == 0, i == 513, $urandom);
      if (write2) nw++;
      if (frame_done) nd++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL overflow_model beat=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (nw !== 512) begin errors++; $display("FAIL overflow_writes got=%0d exp=512", nw); end
    checks++;
    if ({nd, frame_count, ready_bank, ready_words} !== {32'd0, f0, 1'b1, 10'd1}) begin
      errors++; $display("FAIL overflow_publish got=done%0d fc%0d rb%b rw%0d exp=done0 fc%0d rb1 rw1",
                         nd, frame_count, ready_bank, ready_words, f0);
    end
    checks++;
    if (err_count !== e0 + 8'd1) begin
      errors++; $display("FAIL overflow_err got=%0d exp=%0d", err_count, e0 + 8'd1);
    end
  endtask

  task automatic test_err_restart();
    logic [7:0] e0;
    logic [31:0] r;
    e0 = err_count; r = $urandom;
    cycle(1, 1, 0, 0, $urandom);
    checks++;
    if ({write2, err_count} !== {1'b0, e0 + 8'd1}) begin
      errors++; $display("FAIL nosop_idle got=w%b err%0d exp=w0 err%0d", write2, err_count, e0 + 8'd1);
    end
    cycle(1, 1, 1, 0, $urandom);
    cycle(1, 1, 0, 0, $urandom);
    cycle(1, 1, 1, 0, $urandom);
    checks++;
    if ({write2, address2, err_count} !== {1'b1, 10'd0, e0 + 8'd2}) begin
      errors++; $display("FAIL restart_sop got=w%b a%0d err%0d exp=w1 a0 err%0d",
                         write2, address2, err_count, e0 + 8'd2);
    end
    cycle(1, 1, 0, 0, $urandom);
    cycle(1, 1, 0, 1, r);
    checks++;
    if ({write2, address2, writedata2, frame_done, ready_bank, ready_words, err_count} !==
        {1'b1, 10'd2, r, 1'b1, 1'b0, 10'd3, e0 + 8'd2}) begin
      errors++; $display("FAIL restart_publish got=a%0d done%b rb%b rw%0d err%0d exp=a2 done1 rb0 rw3 err%0d",
                         address2, frame_done, ready_bank, ready_words, err_count, e0 + 8'd2);
    end
  endtask

  task automatic test_enable_reset();
    logic [7:0] e0;
    logic [15:0] f0;
    e0 = err_count; f0 = frame_count;
    cycle(1, 1, 1, 0, $urandom);
    cycle(1, 1, 0, 0, $urandom);
    @(negedge clk);
    enable = 0;
    #1;
    checks++;
    if (sif.sink_ready !== 1'b0) begin errors++; $display("FAIL ready_low got=%b exp=0", sif.sink_ready); end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 1, $urandom);
      checks++;
      if ({write2, frame_done, err_count, frame_count} !== {2'b00, e0, f0}) begin
        errors++; $display("FAIL disabled got=w%b done%b err%0d fc%0d exp=w0 done0 err%0d fc%0d",
                           write2, frame_done, err_count, frame_count, e0, f0);
      end
    end
    cycle(1, 1, 0, 1, $urandom);
    checks++;
    if ({write2, frame_done, err_count} !== {2'b00, e0 + 8'd1}) begin
      errors++; $display("FAIL forced_idle got=w%b done%b err%0d exp=w0 done0 err%0d",
                         write2, frame_done, err_count, e0 + 8'd1);
    end
    cycle(1, 1, 1, 0, $urandom);
    checks++;
    if ({write2, address2} !== {1'b1, 10'd512}) begin
      errors++; $display("FAIL bank_kept got=w%b a%0d exp=w1 a512", write2, address2);
    end
    cycle(1, 1, 0, 0, $urandom);
    @(negedge clk);
    #2;
    reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 80'd0) begin errors++; $display("FAIL midreset got=%h exp=0", dut_vec()); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, i == 2, $urandom);
      checks++;
      if (dut_vec() !== 80'd0) begin errors++; $display("FAIL midreset_hold got=%h exp=0", dut_vec()); end
    end
    @(negedge clk);
    sif.sink_valid = 0;
    reset_n = 1;
    cycle(1, 1, 0, 1, $urandom);
    checks++;
    if ({write2, frame_done, frame_count} !== {2'b00, 16'd0}) begin
      errors++; $display("FAIL after_reset got=w%b done%b fc%0d exp=w0 done0 fc0", write2, frame_done, frame_count);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 16) != 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
            ($urandom % 5) == 0, $urandom);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    int nw;
    nw = 0;
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      cycle(1, 1, 0, ($urandom % 2) == 0, $urandom);
      if (write2) nw++;
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd254) begin errors++; $display("FAIL err_count254 got=%0d exp=254", err_count); end
      end
    end
    checks++;
    if ({nw, err_count} !== {32'd0, 8'd255}) begin
      errors++; $display("FAIL err_saturate got=writes%0d err%0d exp=writes0 err255", nw, err_count);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 65535; i++) cycle(1, 1, 1, 1, i);
    checks++;
    if (frame_count !== 16'd65535) begin
      errors++; $display("FAIL fc_65535 got=%0d exp=65535", frame_count);
    end
    cycle(1, 1, 1, 1, 32'hCAFE_F00D);
    checks++;
    if ({frame_count, frame_done, ready_bank, ready_words, address2} !==
        {16'd0, 1'b1, 1'b1, 10'd1, 10'd512}) begin
      errors++; $display("FAIL fc_wrap got=fc%0d done%b rb%b rw%0d a%0d exp=fc0 done1 rb1 rw1 a512",
                         frame_count, frame_done, ready_bank, ready_words, address2);
    end
  endtask

  initial begin
    reset_n = 1; enable = 0;
    sif.sink_valid = 0; sif.sink_startofpacket = 0;
    sif.sink_endofpacket = 0; sif.sink_data = '0;
    model_reset();
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_err_restart();
    test_enable_reset();
    test_random();
    test_saturate();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram_stream_writer.md
DATA_RAM_STREAM_WRITER -- requirements
Module: data_ram_stream_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, the data RAM word-address width.
REQ-002 The block SHALL have parameter BANK_WORDS, default 512, the words per ping-pong bank (2^(ADDR_WIDTH-1)).
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_n, input, 1: reset; it SHALL be asynchronous and active-low.
REQ-005 Port enable, input, 1: stream accept enable.
REQ-006 Port sink_valid / sink_ready, input / output, 1 each: stream beat handshake.
REQ-007 Port sink_data, input, 32: stream data word.
REQ-008 Port sink_startofpacket / sink_endofpacket, input, 1 each: frame delimiters.
REQ-009 Port address2, output, ADDR_WIDTH: RAM port-2 word address.
REQ-010 Port writedata2, output, 32: RAM port-2 write data.
REQ-011 Port write2 / chipselect2, output, 1 each: RAM port-2 write strobe; both SHALL be driven identically.
REQ-012 Port byteenable2, output, 4: tied to 4'hF.
REQ-013 Port clken2, output, 1: tied to 1.
REQ-014 Port ready_bank, output, 1: bank holding the newest complete frame.
REQ-015 Port ready_words, output, ADDR_WIDTH: word count of that frame.
REQ-016 Port frame_done, output, 1: one-cycle pulse on frame publish.
REQ-017 Port frame_count, output, 16: published frames, wrapping.
REQ-018 Port err_count, output, 8: malformed/dropped frames, saturating at 255.

Function
REQ-019 sink_ready SHALL equal enable combinationally; a beat is accepted when sink_valid & sink_ready.
REQ-020 Each accepted beat that is written SHALL appear on write2=1, address2, and writedata2 exactly 1 cycle after acceptance; write2 SHALL be 0 in all other cycles.
REQ-021 address2 SHALL equal {wr_bank, offset}, where wr_bank is the internal write bank and offset is the word index within the frame.
REQ-022 FSM states SHALL be IDLE, WRITE, and DROP.
REQ-023 In IDLE, a beat with SOP SHALL be written at offset 0, set offset to 1, and go to WRITE; a beat without SOP SHALL be discarded and increment err_count.
REQ-024 In WRITE, a beat without SOP SHALL be written at offset, and offset SHALL increment.
REQ-025 In WRITE, a beat with SOP SHALL restart the frame at offset 0 in the same bank, discard the partial frame, and increment err_count.
REQ-026 A written beat with EOP (including SOP&EOP in IDLE) SHALL publish the frame: ready_bank<=wr_bank, ready_words<=offset+1, wr_bank toggles, frame_count++, frame_done=1 for 1 cycle, next state IDLE.
REQ-027 frame_done, ready_bank, and ready_words SHALL update in the same cycle as the final write2 of the frame.
REQ-028 In WRITE, a beat arriving with offset==BANK_WORDS SHALL NOT be written; the state SHALL go to DROP and err_count SHALL increment once.
REQ-029 In DROP, beats SHALL be discarded; EOP SHALL go to IDLE; SOP (without EOP) SHALL behave as SOP in IDLE.
REQ-030 An unpublished bank SHALL never be reported in ready_bank; the reader always has one stable bank.
REQ-031 enable low in WRITE or DROP SHALL force IDLE on the next edge, discard the partial frame, leave err_count unchanged, and keep wr_bank.

Reset
REQ-032 While reset_n=0, all registered outputs SHALL be 0: write2, chipselect2, address2, writedata2, ready_bank, ready_words, frame_done, frame_count, and err_count; additionally, the state SHALL be IDLE, wr_bank 0, and offset 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no publish and no further writes after assertion.

Verification
REQ-034 3-beat frame {SOP,A},{B},{EOP,C} into bank 0: the bench SHALL check writes at addr 0,1,2 each 1 cycle after acceptance; frame_done pulses with the C write; ready_bank=0, ready_words=3, frame_count=1, next frame targets addr 512.
REQ-035 Single beat SOP&EOP: the bench SHALL check one write and ready_words=1.
REQ-036 513-beat frame: the bench SHALL check 512 writes, no write for beat 513, err_count=1, no frame_done, and no publish on the trailing EOP.
REQ-037 Beat without SOP in IDLE, then SOP mid-frame: the bench SHALL check err_count=2 and that the restarted frame publishes correctly at offset 0.
REQ-038 enable dropped mid-frame, then reset_n pulsed mid-frame: the bench SHALL check sink_ready=0, no publish, and all outputs 0 during reset.
REQ-039 err_count SHALL stick at 255 after 260 malformed beats, and frame_count SHALL wrap from 65535 to 0.
